// File: rtl/beep_pkg.sv
// Shared types and constants for the melody buzzer: note codes, period table,
// ROM entry layout and controller states.
package beep_pkg;

    localparam logic [3:0] REST  = 4'd0;
    localparam logic [3:0] DO    = 4'd1;
    localparam logic [3:0] RE    = 4'd2;
    localparam logic [3:0] MI    = 4'd3;
    localparam logic [3:0] FA    = 4'd4;
    localparam logic [3:0] SO    = 4'd5;
    localparam logic [3:0] LA    = 4'd6;
    localparam logic [3:0] XI    = 4'd7;
    localparam logic [3:0] DO_H  = 4'd8;
    localparam logic [3:0] RE_H  = 4'd9;
    localparam logic [3:0] MI_H  = 4'd10;
    localparam logic [3:0] FA_H  = 4'd11;
    localparam logic [3:0] SO_H  = 4'd12;
    localparam logic [3:0] LA_H  = 4'd13;
    localparam logic [3:0] XI_H  = 4'd14;

    localparam logic [17:0] P_DO = 18'd190839;
    localparam logic [17:0] P_RE = 18'd170067;
    localparam logic [17:0] P_MI = 18'd151514;
    localparam logic [17:0] P_FA = 18'd143265;
    localparam logic [17:0] P_SO = 18'd127550;
    localparam logic [17:0] P_LA = 18'd113635;
    localparam logic [17:0] P_XI = 18'd101213;

    // ROM word: code in [6:3], beats (duration minus one) in [2:0]
    typedef struct packed {
        logic [3:0] code;
        logic [2:0] beats;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    function automatic logic [17:0] note_period(input logic [3:0] code);
        logic [17:0] p;
        case (code)
            DO:      p = P_DO;
            RE:      p = P_RE;
            MI:      p = P_MI;
            FA:      p = P_FA;
            SO:      p = P_SO;
            LA:      p = P_LA;
            XI:      p = P_XI;
            DO_H:    p = P_DO >> 1;
            RE_H:    p = P_RE >> 1;
            MI_H:    p = P_MI >> 1;
            FA_H:    p = P_FA >> 1;
            SO_H:    p = P_SO >> 1;
            LA_H:    p = P_LA >> 1;
            XI_H:    p = P_XI >> 1;
            default: p = 18'd0;
        endcase
        return p;
    endfunction

    // Code 15 is unassigned and is treated as silence
    function automatic logic is_rest(input logic [3:0] code);
        return (code == REST) || (code == 4'd15);
    endfunction

endpackage

// File: rtl/beep_melody_rom.sv
// Default song ROM; replace the table contents per project.
module melody_rom
    import beep_pkg::*;
(
    input  logic [3:0] idx_i,
    output entry_t     entry_o
);

    // Sixteen-entry song lookup
    always_comb begin
        entry_o = '{code: REST, beats: 3'd0};
        case (idx_i)
            4'd0:    entry_o = '{code: DO,   beats: 3'd1};
            4'd1:    entry_o = '{code: REST, beats: 3'd0};
            4'd2:    entry_o = '{code: RE,   beats: 3'd0};
            4'd3:    entry_o = '{code: MI,   beats: 3'd0};
            4'd4:    entry_o = '{code: FA,   beats: 3'd1};
            4'd5:    entry_o = '{code: SO,   beats: 3'd0};
            4'd6:    entry_o = '{code: LA,   beats: 3'd0};
            4'd7:    entry_o = '{code: XI,   beats: 3'd1};
            4'd8:    entry_o = '{code: DO_H, beats: 3'd2};
            4'd9:    entry_o = '{code: XI,   beats: 3'd0};
            4'd10:   entry_o = '{code: LA,   beats: 3'd0};
            4'd11:   entry_o = '{code: SO,   beats: 3'd1};
            4'd12:   entry_o = '{code: FA,   beats: 3'd0};
            4'd13:   entry_o = '{code: MI,   beats: 3'd0};
            4'd14:   entry_o = '{code: RE,   beats: 3'd0};
            4'd15:   entry_o = '{code: DO,   beats: 3'd3};
            default: entry_o = '{code: REST, beats: 3'd0};
        endcase
    end

endmodule

// File: rtl/beep_melody.sv
// Melody player: steps through the song ROM, generating a duty-controlled
// square wave per note with a silent gap between notes.
module beep_melody
    import beep_pkg::*;
#(
    parameter logic [24:0] BEAT_TICKS   = 25'd12_499_999,
    parameter logic [21:0] GAP_TICKS    = 22'd2_499_999,
    parameter int unsigned SONG_LEN     = 16,
    parameter bit          LOOP         = 1'b1,
    parameter int unsigned DUTY_SHIFT   = 1,
    parameter int unsigned PERIOD_SHIFT = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic       done,
    output logic [3:0] note_idx
);

    localparam logic [3:0] LAST_IDX = 4'(SONG_LEN - 1);

    state_t      state_q;
    logic [3:0]  note_idx_q;
    logic [17:0] period_q;
    logic        rest_q;
    logic [2:0]  beats_q;
    logic [24:0] tick_q;
    logic [2:0]  beat_q;
    logic [21:0] gap_q;
    logic [17:0] freq_q;
    logic        beep_q;
    logic        busy_q;
    logic        done_q;

    entry_t      rom_entry_s;
    logic        tone_d;
    logic [17:0] freq_d;
    logic        play_end_s;
    logic        gap_end_s;

    melody_rom u_rom (
        .idx_i   (note_idx_q),
        .entry_o (rom_entry_s)
    );

    assign play_end_s = (tick_q == BEAT_TICKS) && (beat_q == beats_q);
    assign gap_end_s  = (gap_q == GAP_TICKS);

    // Tone level and phase-counter wrap for the current PLAY cycle
    always_comb begin
        tone_d = 1'b0;
        freq_d = 18'd0;
        if (!rest_q && !mute && (freq_q > (period_q >> DUTY_SHIFT))) begin
            tone_d = 1'b1;
        end else begin
            tone_d = 1'b0;
        end
        if (freq_q == period_q) begin
            freq_d = 18'd0;
        end else begin
            freq_d = freq_q + 18'd1;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            note_idx_q <= 4'd0;
            period_q   <= 18'd0;
            rest_q     <= 1'b1;
            beats_q    <= 3'd0;
            tick_q     <= 25'd0;
            beat_q     <= 3'd0;
            gap_q      <= 22'd0;
            freq_q     <= 18'd0;
            beep_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (stop) begin
            // stop also masks a coincident start while idle
            state_q    <= IDLE;
            note_idx_q <= 4'd0;
            beep_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    beep_q <= 1'b0;
                    if (start) begin
                        state_q    <= LOAD;
                        note_idx_q <= 4'd0;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    period_q <= note_period(rom_entry_s.code) >> PERIOD_SHIFT;
                    rest_q   <= is_rest(rom_entry_s.code);
                    beats_q  <= rom_entry_s.beats;
                    tick_q   <= 25'd0;
                    beat_q   <= 3'd0;
                    freq_q   <= 18'd0;
                    beep_q   <= 1'b0;
                    state_q  <= PLAY;
                end
                PLAY: begin
                    freq_q <= freq_d;
                    if (tick_q == BEAT_TICKS) begin
                        tick_q <= 25'd0;
                        beat_q <= beat_q + 3'd1;
                    end else begin
                        tick_q <= tick_q + 25'd1;
                    end
                    if (play_end_s) begin
                        beep_q  <= 1'b0;
                        gap_q   <= 22'd0;
                        state_q <= GAP;
                    end else begin
                        beep_q  <= tone_d;
                    end
                end
                GAP: begin
                    beep_q <= 1'b0;
                    if (!gap_end_s) begin
                        gap_q <= gap_q + 22'd1;
                    end else if (note_idx_q != LAST_IDX) begin
                        note_idx_q <= note_idx_q + 4'd1;
                        state_q    <= LOAD;
                    end else if (LOOP) begin
                        note_idx_q <= 4'd0;
                        state_q    <= LOAD;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    beep_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign beep     = beep_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign note_idx = note_idx_q;

endmodule

// File: tb/tb_beep_melody.sv
// Directed bench for beep_melody: a one-shot instance (A) and a looping,
// quarter-duty instance (B), both on a 2-entry song with short timing.
module tb_beep_melody;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, stop_a = 1'b0, mute_a = 1'b0;
    logic       start_b = 1'b0, stop_b = 1'b0, mute_b = 1'b0;
    logic       beep_a, busy_a, done_a, beep_b, busy_b, done_b;
    logic [3:0] idx_a, idx_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    beep_melody #(
        .BEAT_TICKS(25'd99), .GAP_TICKS(22'd9), .SONG_LEN(2), .LOOP(1'b0),
        .DUTY_SHIFT(1), .PERIOD_SHIFT(10)
    ) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start_a), .stop(stop_a),
        .mute(mute_a), .beep(beep_a), .busy(busy_a), .done(done_a),
        .note_idx(idx_a)
    );

    beep_melody #(
        .BEAT_TICKS(25'd99), .GAP_TICKS(22'd9), .SONG_LEN(2), .LOOP(1'b1),
        .DUTY_SHIFT(2), .PERIOD_SHIFT(10)
    ) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start_b), .stop(stop_b),
        .mute(mute_b), .beep(beep_b), .busy(busy_b), .done(done_b),
        .note_idx(idx_b)
    );

    typedef struct {
        int         cyc;
        logic       beep;
        logic       busy;
        logic       done;
        logic [3:0] idx;   // 4'hF: not checked
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p, high0, high1, dones;
        int hp [3];
        int muted_high;

        // Edge numbers count posedges after the one that samples start
        vt[0]  = '{0,   1'b0, 1'b1, 1'b0, 4'd0};
        vt[1]  = '{1,   1'b0, 1'b1, 1'b0, 4'd0};
        vt[2]  = '{95,  1'b0, 1'b1, 1'b0, 4'd0};
        vt[3]  = '{96,  1'b1, 1'b1, 1'b0, 4'd0};
        vt[4]  = '{188, 1'b1, 1'b1, 1'b0, 4'd0};
        vt[5]  = '{189, 1'b0, 1'b1, 1'b0, 4'd0};
        vt[6]  = '{200, 1'b0, 1'b1, 1'b0, 4'd0};
        vt[7]  = '{201, 1'b0, 1'b1, 1'b0, 4'd0};
        vt[8]  = '{210, 1'b0, 1'b1, 1'b0, 4'd0};
        vt[9]  = '{211, 1'b0, 1'b1, 1'b0, 4'd1};
        vt[10] = '{300, 1'b0, 1'b1, 1'b0, 4'd1};
        vt[11] = '{321, 1'b0, 1'b1, 1'b0, 4'd1};
        vt[12] = '{322, 1'b0, 1'b0, 1'b1, 4'hF};
        vt[13] = '{323, 1'b0, 1'b0, 1'b0, 4'hF};

        #12;
        check("reset.beep", int'(beep_a), 0);
        check("reset.busy", int'(busy_a), 0);
        check("reset.done", int'(done_a), 0);
        check("reset.idx",  int'(idx_a), 0);
        rst_n = 1'b1;
        step();

        // One-shot playback against the vector table
        p = 0; high0 = 0; high1 = 0; dones = 0;
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int n = 0; n <= 330; n++) begin
            if (p < NV && vt[p].cyc == n) begin
                check($sformatf("vecA[%0d].beep", n), int'(beep_a), int'(vt[p].beep));
                check($sformatf("vecA[%0d].busy", n), int'(busy_a), int'(vt[p].busy));
                check($sformatf("vecA[%0d].done", n), int'(done_a), int'(vt[p].done));
                if (vt[p].idx != 4'hF)
                    check($sformatf("vecA[%0d].idx", n), int'(idx_a), int'(vt[p].idx));
                p++;
            end
            if (beep_a && n <= 211) high0++;
            else if (beep_a) high1++;
            if (done_a) dones++;
            step();
        end
        check("oneshot.vectors_reached", p, NV);
        check("oneshot.high_cycles_do", high0, 93);
        check("oneshot.high_cycles_rest", high1, 0);
        check("oneshot.done_pulses", dones, 1);

        // stop while the tone is high
        start_a = 1'b1; step(); start_a = 1'b0;
        repeat (150) step();
        check("stop.beep_before", int'(beep_a), 1);
        stop_a = 1'b1; step(); stop_a = 1'b0;
        check("stop.beep", int'(beep_a), 0);
        check("stop.busy", int'(busy_a), 0);
        check("stop.idx",  int'(idx_a), 0);
        dones = 0;
        for (int n = 0; n < 400; n++) begin
            if (done_a) dones++;
            step();
        end
        check("stop.no_done", dones, 0);
        check("stop.still_idle", int'(busy_a), 0);

        // start and stop together while idle
        start_a = 1'b1; stop_a = 1'b1; step(); start_a = 1'b0; stop_a = 1'b0;
        check("startstop.busy", int'(busy_a), 0);
        repeat (5) step();
        check("startstop.busy_later", int'(busy_a), 0);

        // start while busy must not restart
        start_a = 1'b1; step(); start_a = 1'b0;
        repeat (100) step();
        start_a = 1'b1; step(); start_a = 1'b0;
        repeat (49) step();
        check("rebusy.beep150", int'(beep_a), 1);
        repeat (61) step();
        check("rebusy.idx211", int'(idx_a), 1);
        repeat (111) step();
        check("rebusy.done322", int'(done_a), 1);
        check("rebusy.busy322", int'(busy_a), 0);
        step();
        check("rebusy.done323", int'(done_a), 0);

        // Loop mode over three passes of 322 edges each
        dones = 0;
        for (int i = 0; i < 3; i++) hp[i] = 0;
        start_b = 1'b1; step(); start_b = 1'b0;
        for (int n = 0; n <= 966; n++) begin
            if (n == 533) check("loop.idx533", int'(idx_b), 1);
            if (n == 322 || n == 644) begin
                check($sformatf("loop.idx%0d", n), int'(idx_b), 0);
                check($sformatf("loop.busy%0d", n), int'(busy_b), 1);
            end
            if (n == 370) check("loop.beep370", int'(beep_b), 0);
            if (n == 371) check("loop.beep371", int'(beep_b), 1);
            if (n >= 1 && beep_b) hp[(n - 1) / 322]++;
            if (done_b) dones++;
            step();
        end
        check("loop.no_done", dones, 0);
        for (int i = 0; i < 3; i++) check($sformatf("loop.high_pass%0d", i), hp[i], 140);
        stop_b = 1'b1; step(); stop_b = 1'b0;
        check("loop.stopped", int'(busy_b), 0);

        // mute for the first 300 edges, then quarter-duty tone on the next pass
        muted_high = 0;
        mute_b = 1'b1; start_b = 1'b1; step(); start_b = 1'b0;
        for (int n = 0; n <= 522; n++) begin
            if (n >= 1 && n <= 322 && beep_b) muted_high++;
            if (n == 211) check("mute.idx211", int'(idx_b), 1);
            if (n == 322) check("mute.idx322", int'(idx_b), 0);
            if (n == 370) check("mute.beep370", int'(beep_b), 0);
            if (n == 371) check("mute.beep371", int'(beep_b), 1);
            if (n == 510) check("mute.beep510", int'(beep_b), 1);
            if (n == 511) check("mute.beep511", int'(beep_b), 0);
            if (n == 300) mute_b = 1'b0;
            step();
        end
        check("mute.high_while_muted", muted_high, 0);
        stop_b = 1'b1; step(); stop_b = 1'b0;

        // asynchronous reset in mid-song, sampled before the next edge
        start_b = 1'b1; step(); start_b = 1'b0;
        repeat (80) step();
        start_a = 1'b1; step(); start_a = 1'b0;
        repeat (150) step();
        check("arst.beep_before", int'(beep_a), 1);
        check("arst.idx_b_before", int'(idx_b), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.beep", int'(beep_a), 0);
        check("arst.busy", int'(busy_a), 0);
        check("arst.idx_a", int'(idx_a), 0);
        check("arst.idx_b", int'(idx_b), 0);
        check("arst.busy_b", int'(busy_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/beep_melody.md
Name: beep_melody

Overview:
- Parametrised successor to the fixed 7-note scale buzzer.
- Plays a programmable melody from an internal song ROM. Each entry carries a note code (rest, 7 mid-octave notes, 7 high-octave notes) and a duration in beat units.
- Adds start/stop control, a one-shot or loop mode, an inter-note gap, a duty-based volume, and mute. Drives the passive buzzer pin directly at the board top level.

Parameters:
- BEAT_TICKS, 25'd12_499_999: cycles per beat unit minus 1 (250 ms at 50 MHz).
- GAP_TICKS, 22'd2_499_999: silent cycles between notes minus 1 (50 ms).
- SONG_LEN, 16: number of ROM entries played, range 1..16.
- LOOP, 1: 1 = restart at entry 0 after the last entry; 0 = stop and pulse done.
- DUTY_SHIFT, 1: high-phase threshold = period >> DUTY_SHIFT. Valid range 1..4; larger values give a quieter output.
- PERIOD_SHIFT, 0: note period = table value >> PERIOD_SHIFT. Non-zero only for simulation speed-up.

Ports:
- sys_clk, input, 1: system clock, 50 MHz.
- sys_rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: 1-cycle pulse. Begins playback at entry 0 when idle.
- stop, input, 1: 1-cycle pulse. Aborts playback.
- mute, input, 1: level. Forces beep low without pausing sequencing.
- beep, output, 1: buzzer drive.
- busy, output, 1: high while a song is in progress.
- done, output, 1: 1-cycle pulse when a one-shot song completes.
- note_idx, output, 4: ROM index currently playing.

Behaviour:
- Reset (async, sys_rst_n low): state IDLE, beep=0, busy=0, done=0, note_idx=0, all counters 0.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: start=1 leads to LOAD with note_idx=0, and busy goes high on the same edge.
  - LOAD: takes 1 cycle. It registers the ROM word at note_idx, sets period = NOTE_TABLE[code] >> PERIOD_SHIFT and dur_cnt = 0, then goes to PLAY.
  - PLAY: dur_cnt counts to (beats+1)*(BEAT_TICKS+1)-1 total cycles, implemented as a beat counter plus a tick counter. At terminal count the FSM goes to GAP.
  - GAP: lasts GAP_TICKS+1 cycles with beep=0. At its end:
    - If note_idx < SONG_LEN-1: note_idx+1, then LOAD.
    - Else if LOOP=1: note_idx=0, then LOAD.
    - Else: IDLE, busy=0, done=1 for one cycle.
- Tone generation in PLAY:
  - freq_cnt runs 0..period, then wraps to 0.
  - freq_cnt is cleared on entry to PLAY, so every note starts phase-aligned.
  - beep is registered: beep=0 when freq_cnt <= (period >> DUTY_SHIFT), else 1.
- Rest code (0): beep stays 0 for the full duration; timing is identical to a tone.
- mute=1: beep=0 on the next edge. Counters and the FSM are unaffected.
- stop=1 in any non-IDLE state: next edge goes to IDLE with beep=0, busy=0, note_idx=0, and no done pulse.
- stop and start asserted in the same cycle: stop wins, and start is ignored.
- start while busy: ignored, no restart.
- beep is 0 whenever the state is not PLAY.
- Latency: start edge to the first possible beep=1 equals 2 cycles (LOAD, then the first PLAY edge) plus the low half-period.
- Width rules:
  - period is 18 bits unsigned.
  - Entries with an unused code (15) play as a rest.
  - beats field is 3 bits, giving durations of 1..8 units.

Decomposition:
- Package beep_pkg holds:
  - Note code constants: REST=0, DO..XI=1..7, DO_H..XI_H=8..14.
  - NOTE_TABLE of 18-bit periods: DO=190839, RE=170067, MI=151514, FA=143265, SO=127550, LA=113635, XI=101213. High octave = mid value >> 1.
  - Entry layout: code [6:3], beats [2:0].
- Sub-module melody_rom: combinational 16x7 lookup, indexed by note_idx, holding the default song. It is swapped per project.

Test Plan:
- Reset mid-PLAY (BEAT_TICKS=99, PERIOD_SHIFT=10): drop sys_rst_n asynchronously -> beep, busy and note_idx are 0 immediately, before the next clock edge.
- One-shot playback (LOOP=0, SONG_LEN=2, ROM {DO,1 beat},{REST,0}, BEAT_TICKS=99, GAP_TICKS=9, PERIOD_SHIFT=10):
  - Pulse start -> busy=1 on the next edge.
  - beep toggles with period 187 cycles (190839>>10=186, counting 0..186); high phase lasts 93 cycles.
  - Entry 0 lasts 200 cycles; entry 1 stays silent for 100 cycles.
  - done pulses exactly once, after the last gap; busy then falls.
- Loop mode (LOOP=1, same ROM) -> after the entry 1 gap, note_idx returns to 0 and the DO tone resumes; done never asserts over 3 passes.
- stop during PLAY and simultaneous start+stop:
  - stop at cycle 50 of PLAY -> beep=0, busy=0, note_idx=0 on the next edge, no done.
  - start+stop in the same cycle while idle -> busy stays 0.
- mute and DUTY_SHIFT=2: mute high for 300 cycles -> beep held 0 while note_idx still advances on schedule; after unmute, high phase = 187-47=140 cycles per period (freq_cnt > 46).
- start while busy -> ignored; note_idx and duration counters continue undisturbed.
